// File: rtl/pwm_leds_wb_if.sv
// Wishbone slave bus bundle for the PWM LED block, as seen on the shared wbm_* bus.
interface pwm_leds_wb_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] wbs_address;
  logic [DATA_WIDTH-1:0] wbs_writedata;
  logic [DATA_WIDTH-1:0] wbs_readdata;
  logic                  wbs_write;
  logic                  wbs_strobe;
  logic                  wbs_cycle;
  logic                  wbs_ack;

  modport master (
    output wbs_address, wbs_writedata, wbs_write, wbs_strobe, wbs_cycle,
    input  wbs_readdata, wbs_ack
  );

  modport slave (
    input  wbs_address, wbs_writedata, wbs_write, wbs_strobe, wbs_cycle,
    output wbs_readdata, wbs_ack
  );
endinterface

// File: rtl/pwm_leds_wb.sv
// Four-channel 8-bit PWM LED driver with a shared 16-bit prescaler.
// Duty registers are double-buffered and only take effect at a period boundary.
module pwm_leds_wb #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_LEDS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_LEDS-1:0] led,
  pwm_leds_wb_if.slave        wbs
);

  localparam int unsigned PSC_W = 16;
  localparam int unsigned CNT_W = 8;

  logic [ADDR_WIDTH-1:0] w_addr_full;
  logic [2:0]            w_addr;
  logic                  w_req;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_clr;
  logic                  w_duty_wr;
  logic                  w_tick;
  logic                  w_wrap;
  logic [DATA_WIDTH-1:0] w_rdata;

  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [3:0]            r_en;
  logic [3:0]            r_inv;
  logic [PSC_W-1:0]      r_prescale;
  logic [PSC_W-1:0]      r_psc_cnt;
  logic [CNT_W-1:0]      r_pwm_cnt;
  logic                  r_pend;
  logic [CNT_W-1:0]      r_duty_shd [NUM_LEDS];
  logic [CNT_W-1:0]      r_duty_act [NUM_LEDS];
  logic [NUM_LEDS-1:0]   r_led;

  assign w_addr_full = wbs.wbs_address;
  assign w_addr      = w_addr_full[2:0];
  assign w_req       = wbs.wbs_cycle & wbs.wbs_strobe & ~r_ack;
  assign w_wr        = w_req & wbs.wbs_write;
  assign w_rd        = w_req & ~wbs.wbs_write;
  assign w_clr       = w_wr & (w_addr == 3'd0) & wbs.wbs_writedata[8];
  assign w_duty_wr   = w_wr & w_addr[2] & ({1'b0, w_addr[1:0]} < 3'(NUM_LEDS));
  // >= rather than == so a PRESCALE lowered below the running count still ticks
  assign w_tick      = (r_psc_cnt >= r_prescale);
  assign w_wrap      = w_tick & (r_pwm_cnt == 8'hFF);

  // Read mux; DUTY reads return the shadow copy
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      3'd0:    w_rdata = DATA_WIDTH'({r_inv, r_en});
      3'd1:    w_rdata = DATA_WIDTH'(r_prescale);
      3'd2:    w_rdata = DATA_WIDTH'({r_pend, r_pwm_cnt});
      default: ;
    endcase
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (w_addr == 3'(4 + i)) w_rdata = DATA_WIDTH'(r_duty_shd[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_req;
      if (w_rd) r_rdata <= w_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en       <= '0;
      r_inv      <= '0;
      r_prescale <= '0;
    end else if (w_wr) begin
      if (w_addr == 3'd0) begin
        r_en  <= wbs.wbs_writedata[3:0];
        r_inv <= wbs.wbs_writedata[7:4];
      end
      if (w_addr == 3'd1) r_prescale <= wbs.wbs_writedata[PSC_W-1:0];
    end
  end

  // Prescaler and period counter; CLR outranks a same-cycle tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_psc_cnt <= '0;
      r_pwm_cnt <= '0;
      r_pend    <= 1'b0;
    end else begin
      if (w_clr) begin
        r_psc_cnt <= '0;
        r_pwm_cnt <= '0;
      end else if (w_tick) begin
        r_psc_cnt <= '0;
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end else begin
        r_psc_cnt <= r_psc_cnt + 16'd1;
      end
      if (w_clr)          r_pend <= 1'b0;
      else if (w_duty_wr) r_pend <= 1'b1;
      else if (w_wrap)    r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_duty_shd[i] <= '0;
        r_duty_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (w_wr && (w_addr == 3'(4 + i))) r_duty_shd[i] <= wbs.wbs_writedata[CNT_W-1:0];
        if (w_clr || w_wrap)              r_duty_act[i] <= r_duty_shd[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        r_led[i] <= r_inv[i] ^ (r_en[i] & (r_pwm_cnt < r_duty_act[i]));
      end
    end
  end

  assign led              = r_led;
  assign wbs.wbs_ack      = r_ack;
  assign wbs.wbs_readdata = r_rdata;

endmodule
